memory_reader: RTL and testbench

// Read side of the two-bank (ping-pong) sample memory. The write controller fills
// one bank while this block streams a finished bank out over a valid/ready interface,
// one word at a time, to the spectrogram datapath. It consumes the write controller's

---
 rtl/memory_reader_if.sv | 24 ++
 rtl/memory_reader.sv | 156 +++++++++++++++
 tb/tb_memory_reader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_reader_if.sv
// Sample stream from the memory reader to the spectrogram datapath.
// The master (memory_reader) presents a word with valid/last, and the slave accepts it with ready.
interface memory_reader_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              sample_last;
    logic              sample_ready;

    modport master (
        output sample_out,
        output sample_valid,
        output sample_last,
        input  sample_ready
    );

    modport slave (
        input  sample_out,
        input  sample_valid,
        input  sample_last,
        output sample_ready
    );
endinterface

// File: rtl/memory_reader.sv
// Read side of the ping-pong sample memory.
// Streams a finished bank out one word at a time over a valid/ready interface.
// One extra frame event can wait in a single pending slot. Any further event is dropped
// and sets the sticky overrun flag.
module memory_reader #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 200,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bank0_full,
    input  logic              bank1_full,
    input  logic              memorization_completed,
    input  logic              bank,
    input  logic [7:0]        idx_final,
    input  logic [DATA_W-1:0] rd_data,
    output logic [8:0]        rd_addr,
    output logic              rd_en,
    output logic              frame_bank,
    output logic              busy,
    output logic              overrun,
    memory_reader_if.master   smp
);

    localparam logic [7:0]       LAST_FULL = 8'(FRAME_LEN - 1);
    localparam int               CNT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, READ, WAIT, HOLD} state_t;

    state_t            state, state_nxt;
    logic [7:0]        idx, last;
    logic [CNT_W-1:0]  wait_cnt;
    logic              pend_valid, pend_bank;
    logic [7:0]        pend_last;
    logic [DATA_W-1:0] sample_q;
    logic              last_q;

    logic              ev_valid, ev_bank;
    logic [7:0]        ev_last;
    logic              xfer, word_last, frame_done, wait_done;

    // Decode the writer's status pulses into a single frame event.
    // A full-bank pulse takes priority over memorization_completed.
    always_comb begin
        ev_valid = bank0_full | bank1_full | memorization_completed;
        ev_bank  = 1'b0;
        ev_last  = LAST_FULL;
        if (bank0_full) begin
            ev_bank = 1'b0;
        end else if (bank1_full) begin
            ev_bank = 1'b1;
        end else begin
            ev_bank = bank;
            ev_last = (idx_final > LAST_FULL) ? LAST_FULL : idx_final;
        end
    end

    assign xfer       = (state == HOLD) && smp.sample_ready;
    assign word_last  = (idx == last);
    assign frame_done = xfer && word_last;
    assign wait_done  = (state == WAIT) && (wait_cnt == CNT_END);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ev_valid) state_nxt = READ;
            READ: state_nxt = WAIT;
            WAIT: if (wait_done) state_nxt = HOLD;
            HOLD: if (xfer) begin
                if (!word_last || pend_valid || ev_valid) state_nxt = READ;
                else                                      state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame, index, read-latency and sample registers, plus the pending slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_bank <= 1'b0;
            last       <= '0;
            idx        <= '0;
            wait_cnt   <= '0;
            sample_q   <= '0;
            last_q     <= 1'b0;
            pend_valid <= 1'b0;
            pend_bank  <= 1'b0;
            pend_last  <= '0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ev_valid) begin
                    frame_bank <= ev_bank;
                    last       <= ev_last;
                    idx        <= '0;
                end
                READ: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_done) begin
                        sample_q <= rd_data;
                        last_q   <= word_last;
                    end
                end
                HOLD: if (xfer) begin
                    if (!word_last) begin
                        idx <= idx + 8'd1;
                    end else if (pend_valid) begin
                        frame_bank <= pend_bank;
                        last       <= pend_last;
                        idx        <= '0;
                    end else if (ev_valid) begin
                        frame_bank <= ev_bank;
                        last       <= ev_last;
                        idx        <= '0;
                    end
                end
                default: ;
            endcase

            // An event that arrives while the slot is empty and the last word is
            // transferring is started directly above, so it is not stored here.
            if (state != IDLE && ev_valid) begin
                if (pend_valid) begin
                    overrun <= 1'b1;
                end else if (!frame_done) begin
                    pend_valid <= 1'b1;
                    pend_bank  <= ev_bank;
                    pend_last  <= ev_last;
                end
            end
            if (frame_done && pend_valid) pend_valid <= 1'b0;
        end
    end

    // Moore outputs.
    always_comb begin
        rd_en            = (state == READ);
        busy             = (state != IDLE);
        smp.sample_valid = (state == HOLD);
        smp.sample_last  = (state == HOLD) && last_q;
    end

    assign rd_addr        = {frame_bank, idx};
    assign smp.sample_out = sample_q;

endmodule

// File: tb/tb_memory_reader.sv
// Scoreboard bench for memory_reader.
// The stimulus pushes the expected words into a queue. A monitor pops an entry on each
// valid/ready transfer and compares it.
module tb_memory_reader;
    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = 200;
    localparam int RD_LAT    = 1;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        bank;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        bank0_full, bank1_full, memorization_completed, bank;
    logic [7:0]  idx_final;
    logic [15:0] rd_data;
    logic [8:0]  rd_addr;
    logic        rd_en, frame_bank, busy, overrun;

    memory_reader_if #(.DATA_W(DATA_W)) smp ();

    memory_reader #(
        .DATA_W(DATA_W),
        .FRAME_LEN(FRAME_LEN),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bank0_full(bank0_full),
        .bank1_full(bank1_full),
        .memorization_completed(memorization_completed),
        .bank(bank),
        .idx_final(idx_final),
        .rd_data(rd_data),
        .rd_addr(rd_addr),
        .rd_en(rd_en),
        .frame_bank(frame_bank),
        .busy(busy),
        .overrun(overrun),
        .smp(smp)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   xfers = 0;

    function automatic logic [15:0] mem_word(input logic [8:0] a);
        return {7'h55, a};
    endfunction

    // Memory model with one cycle of read latency. Outside a read it returns garbage.
    always @(posedge clk) rd_data <= rd_en ? mem_word(rd_addr) : 16'hDEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic b, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = mem_word({b, 8'(i)});
            e.last = (i == n - 1);
            e.bank = b;
            q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            tick();
            if (!busy && q.size() == 0) done = 1'b1;
        end
        check({name, "_finished"}, {31'b0, done}, 32'd1);
        check({name, "_queue_empty"}, q.size(), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rd_en"}, {31'b0, rd_en}, 32'd0);
        check({name, "_rd_addr"}, {23'b0, rd_addr}, 32'd0);
        check({name, "_sample_out"}, {16'b0, smp.sample_out}, 32'd0);
        check({name, "_sample_valid"}, {31'b0, smp.sample_valid}, 32'd0);
        check({name, "_sample_last"}, {31'b0, smp.sample_last}, 32'd0);
        check({name, "_frame_bank"}, {31'b0, frame_bank}, 32'd0);
        check({name, "_busy"}, {31'b0, busy}, 32'd0);
        check({name, "_overrun"}, {31'b0, overrun}, 32'd0);
    endtask

    // Monitor: checks held words stay stable and pops the scoreboard on each transfer.
    logic [15:0] held_data;
    logic        held_last;
    logic        holding = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            holding <= 1'b0;
        end else if (smp.sample_valid) begin
            if (holding) begin
                check("hold_data_stable", {16'b0, smp.sample_out}, {16'b0, held_data});
                check("hold_last_stable", {31'b0, smp.sample_last}, {31'b0, held_last});
            end
            if (smp.sample_ready) begin
                holding <= 1'b0;
                xfers   <= xfers + 1;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h expected no word", smp.sample_out);
                end else begin
                    e = q.pop_front();
                    check("word_data", {16'b0, smp.sample_out}, {16'b0, e.data});
                    check("word_last", {31'b0, smp.sample_last}, {31'b0, e.last});
                    check("word_bank", {31'b0, frame_bank}, {31'b0, e.bank});
                end
            end else begin
                holding   <= 1'b1;
                held_data <= smp.sample_out;
                held_last <= smp.sample_last;
            end
        end else begin
            holding <= 1'b0;
        end
    end

    initial begin
        int base;
        logic reached;
        reset = 1'b1;
        bank0_full = 1'b0;
        bank1_full = 1'b0;
        memorization_completed = 1'b0;
        bank = 1'b0;
        idx_final = '0;
        smp.sample_ready = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Full bank 0 frame: check the latency timing, then drain 200 words.
        push_frame(1'b0, 200);
        bank0_full = 1'b1;
        tick();
        bank0_full = 1'b0;
        check("t1_rd_en_cycle1", {31'b0, rd_en}, 32'd1);
        check("t1_rd_addr_first", {23'b0, rd_addr}, 32'h000);
        check("t1_busy", {31'b0, busy}, 32'd1);
        tick();
        check("t1_rd_en_cycle2", {31'b0, rd_en}, 32'd0);
        check("t1_valid_cycle2", {31'b0, smp.sample_valid}, 32'd0);
        tick();
        check("t1_valid_cycle3", {31'b0, smp.sample_valid}, 32'd1);
        wait_idle("t1");

        // Partial frame in bank 1 (idx_final=9), with ready toggling 1-0-1.
        push_frame(1'b1, 10);
        bank = 1'b1;
        idx_final = 8'd9;
        memorization_completed = 1'b1;
        tick();
        memorization_completed = 1'b0;
        for (int i = 0; i < 200 && busy; i++) begin
            smp.sample_ready = (i % 3 != 1);
            tick();
        end
        smp.sample_ready = 1'b1;
        wait_idle("t2");

        // idx_final=0 gives a 1-word frame.
        push_frame(1'b0, 1);
        bank = 1'b0;
        idx_final = 8'd0;
        memorization_completed = 1'b1;
        tick();
        memorization_completed = 1'b0;
        wait_idle("one_word");

        // idx_final beyond the frame is clamped to FRAME_LEN-1.
        push_frame(1'b1, FRAME_LEN);
        bank = 1'b1;
        idx_final = 8'd250;
        memorization_completed = 1'b1;
        tick();
        memorization_completed = 1'b0;
        wait_idle("clamp");

        // Second event goes to the pending slot, third event is dropped.
        push_frame(1'b0, 200);
        push_frame(1'b1, 200);
        bank0_full = 1'b1;
        tick();
        bank0_full = 1'b0;
        repeat (20) tick();
        bank1_full = 1'b1;
        tick();
        bank1_full = 1'b0;
        check("t4_no_overrun_yet", {31'b0, overrun}, 32'd0);
        repeat (20) tick();
        bank0_full = 1'b1;
        tick();
        bank0_full = 1'b0;
        check("t4_overrun_set", {31'b0, overrun}, 32'd1);
        wait_idle("t4");
        check("t4_overrun_sticky", {31'b0, overrun}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_overrun_cleared", {31'b0, overrun}, 32'd0);

        // A full-bank pulse and memorization_completed in the same cycle give one full frame.
        push_frame(1'b0, 200);
        bank = 1'b1;
        idx_final = 8'd5;
        bank0_full = 1'b1;
        memorization_completed = 1'b1;
        tick();
        bank0_full = 1'b0;
        memorization_completed = 1'b0;
        wait_idle("t5");

        // Reset mid-frame after 50 words, then restart from index 0.
        push_frame(1'b1, 200);
        base = xfers;
        bank1_full = 1'b1;
        tick();
        bank1_full = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 1000 && !reached; i++) begin
            tick();
            if (xfers - base >= 50) reached = 1'b1;
        end
        check("t6_reached_50", {31'b0, reached}, 32'd1);
        reset = 1'b1;
        q.delete();
        tick();
        check_all_zero("t6_reset");
        reset = 1'b0;
        tick();
        push_frame(1'b0, 200);
        bank0_full = 1'b1;
        tick();
        bank0_full = 1'b0;
        check("t6_restart_rd_en", {31'b0, rd_en}, 32'd1);
        check("t6_restart_addr", {23'b0, rd_addr}, 32'h000);
        wait_idle("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
